// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared defaults, FSM state encoding and the reset vector
//               for the interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Default geometry: vector 0 is the reset vector, 1..44 are sources
    localparam int c_NUM_VECT = 45;
    localparam int c_VEC_W    = 6;

    // Arbiter FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;
    localparam logic [1:0] c_ST_COOL = 2'd3;

    // Vector number reserved for reset; also the "no source" value
    localparam int c_RESET_VECT = 0;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational lowest-index priority encoder. Reports whether
//               any line is set and the bit index of the lowest set line.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N = 44,
    parameter int W = 6
) (
    input  logic [N-1:0] lines,
    output logic         any,
    output logic [W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        any   = |lines;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (lines[i]) begin
                index = W'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter
// Description : Interrupt arbiter. Picks the lowest-numbered pending source,
//               requests the core, re-arbitrates while waiting, acknowledges
//               the taken vector for one cycle, then cools down for one cycle.
//               A post-RETI guard lets one instruction retire before the next
//               interrupt can be requested.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_VECT = c_NUM_VECT,
    parameter int VEC_W    = c_VEC_W
) (
    input  logic                cp2,
    input  logic                ireset,
    input  logic [NUM_VECT-2:0] irq_lines,
    input  logic                gie,
    input  logic                irq_taken,
    input  logic                reti,
    input  logic                instr_retire,
    output logic                irq_req,
    output logic [VEC_W-1:0]    irq_vector,
    output logic                irqack,
    output logic [VEC_W-1:0]    irqack_addr,
    output logic                irq_busy
);

    localparam logic [VEC_W-1:0] c_RST_VEC = VEC_W'(c_RESET_VECT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [VEC_W-1:0] r_vec;
    logic [VEC_W-1:0] w_vec_nxt;
    logic             r_guard;
    logic             r_irq_req;
    logic [VEC_W-1:0] r_irq_vector;
    logic             r_irqack;
    logic [VEC_W-1:0] r_irqack_addr;

    logic             w_any;
    logic [VEC_W-1:0] w_idx;
    logic [VEC_W-1:0] w_win_vec;
    logic             w_stay_req;
    logic             w_take;

    irq_prio_enc #(
        .N (NUM_VECT - 1),
        .W (VEC_W)
    ) u_prio_enc (
        .lines (irq_lines),
        .any   (w_any),
        .index (w_idx)
    );

    // Bit k-1 carries vector k, so the winning vector is the index plus one
    always_comb begin
        w_win_vec = w_any ? (w_idx + VEC_W'(1)) : c_RST_VEC;
    end

    // Next state and next latched vector; irq_taken outranks any abort
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        case (r_state)
            c_ST_IDLE: begin
                if (gie && !r_guard && w_any) begin
                    w_state_nxt = c_ST_REQ;
                    w_vec_nxt   = w_win_vec;
                end
            end
            c_ST_REQ: begin
                if (irq_taken) begin
                    w_state_nxt = c_ST_ACK;
                end else if (!gie || !w_any) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_vec_nxt = w_win_vec;
                end
            end
            c_ST_ACK:  w_state_nxt = c_ST_COOL;
            c_ST_COOL: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output strobes derived from the transition taken at this edge
    always_comb begin
        w_stay_req = (r_state == c_ST_REQ) && (w_state_nxt == c_ST_REQ);
        w_take     = (r_state == c_ST_REQ) && irq_taken;
    end

    // FSM state and latched vector
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_state <= c_ST_IDLE;
            r_vec   <= c_RST_VEC;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    // Post-RETI guard: a retire in the same cycle as RETI does not count
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_guard <= 1'b0;
        end else if (reti) begin
            r_guard <= 1'b1;
        end else if (instr_retire) begin
            r_guard <= 1'b0;
        end
    end

    // Registered request/acknowledge outputs, zeroed whenever not active
    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            r_irq_req     <= 1'b0;
            r_irq_vector  <= c_RST_VEC;
            r_irqack      <= 1'b0;
            r_irqack_addr <= c_RST_VEC;
        end else begin
            r_irq_req     <= w_stay_req;
            r_irq_vector  <= w_stay_req ? w_vec_nxt : c_RST_VEC;
            r_irqack      <= w_take;
            r_irqack_addr <= w_take ? r_vec : c_RST_VEC;
        end
    end

    assign irq_req     = r_irq_req;
    assign irq_vector  = r_irq_vector;
    assign irqack      = r_irqack;
    assign irqack_addr = r_irqack_addr;
    assign irq_busy    = (r_state != c_ST_IDLE) || r_guard;

endmodule : irq_arbiter
`default_nettype wire
